// File: rtl/linear_pkg.sv
// Shared types and helpers for the linear_mac block: FSM state, default widths,
// and the shift-and-saturate used when a lane's accumulator is written out.
package linear_pkg;
  localparam int IN_SIZE_DEF  = 4;
  localparam int OUT_SIZE_DEF = 4;
  localparam int COUNT_DEF    = 1;
  localparam int DATA_W_DEF   = 32;
  localparam int FRAC_W_DEF   = 16;
  localparam int LANES_DEF    = 1;

  // Wide enough for any accumulator with DATA_W <= 64 and a modest IN_SIZE.
  localparam int SAT_W = 160;

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

  // Arithmetic right shift (floor), then clamp to a signed data_w-bit range.
  function automatic logic signed [SAT_W-1:0] shift_sat(
    input logic signed [SAT_W-1:0] acc,
    input int                      frac_w,
    input int                      data_w
  );
    logic signed [SAT_W-1:0] sh, hi, lo;
    sh = acc >>> frac_w;
    hi = (SAT_W'(1) <<< (data_w - 1)) - SAT_W'(1);
    lo = ~hi;
    if (sh > hi) return hi;
    if (sh < lo) return lo;
    return sh;
  endfunction
endpackage

// File: rtl/linear_mac_if.sv
// Operand/result handshake bundle for linear_mac.
interface linear_mac_if
  import linear_pkg::*;
#(
  parameter int IN_SIZE  = IN_SIZE_DEF,
  parameter int OUT_SIZE = OUT_SIZE_DEF,
  parameter int COUNT    = COUNT_DEF,
  parameter int DATA_W   = DATA_W_DEF
);
  logic                               in_valid;
  logic                               in_ready;
  logic [COUNT*IN_SIZE*DATA_W-1:0]    data_in;
  logic [IN_SIZE*OUT_SIZE*DATA_W-1:0] weights;
  logic [OUT_SIZE*DATA_W-1:0]         biases;
  logic                               out_valid;
  logic                               out_ready;
  logic [COUNT*OUT_SIZE*DATA_W-1:0]   data_out;
  logic                               busy;

  modport master (
    output in_valid, data_in, weights, biases, out_ready,
    input  in_ready, out_valid, data_out, busy
  );
  modport slave (
    input  in_valid, data_in, weights, biases, out_ready,
    output in_ready, out_valid, data_out, busy
  );
endinterface

// File: rtl/mac_lane.sv
// One MAC lane: bias-preloaded accumulate, then floor-shift and saturate to DATA_W.
// Optional ReLU on the stored value when LINEAR_MAC_RELU_EN is defined.
module mac_lane
  import linear_pkg::*;
#(
  parameter int IN_SIZE = IN_SIZE_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int FRAC_W  = FRAC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     acc_en,
  input  logic                     first,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [DATA_W-1:0] b,
  output logic        [DATA_W-1:0] y
);
  localparam int AW = 2*DATA_W + $clog2(IN_SIZE) + 1;

  if (AW > SAT_W) begin : g_chk
    $error("mac_lane accumulator wider than SAT_W");
  end

  logic signed [2*DATA_W-1:0] prod;
  logic signed [AW-1:0]       acc, pre, prod_x;
  logic signed [SAT_W-1:0]    sat;
  logic                       sat_unused;

  assign prod   = x * w;
  assign prod_x = AW'(prod);
  assign pre    = AW'(b) <<< FRAC_W;

  // First term of each dot product folds in the bias, so no separate preload cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        acc <= '0;
    else if (acc_en) acc <= (first ? pre : acc) + prod_x;
  end

  assign sat        = shift_sat(SAT_W'(acc), FRAC_W, DATA_W);
  assign sat_unused = ^sat;

`ifdef LINEAR_MAC_RELU_EN
  assign y = sat[DATA_W-1] ? '0 : sat[DATA_W-1:0];
`else
  assign y = sat[DATA_W-1:0];
`endif
endmodule

// File: rtl/linear_mac.sv
// Fixed-point y = x*W + b over COUNT rows, LANES outputs computed in parallel.
// Optional feature macro: LINEAR_MAC_RELU_EN (clamps negative results to 0).
module linear_mac
  import linear_pkg::*;
#(
  parameter int IN_SIZE  = IN_SIZE_DEF,
  parameter int OUT_SIZE = OUT_SIZE_DEF,
  parameter int COUNT    = COUNT_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int FRAC_W   = FRAC_W_DEF,
  parameter int LANES    = LANES_DEF
) (
  input logic         clk,
  input logic         rst,
  linear_mac_if.slave bus
);
  localparam int GROUPS = OUT_SIZE / LANES;
  localparam int KW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int GW = (GROUPS  > 1) ? $clog2(GROUPS)  : 1;
  localparam int RW = (COUNT   > 1) ? $clog2(COUNT)   : 1;

  if (OUT_SIZE % LANES != 0) begin : g_chk
    $error("OUT_SIZE must be a multiple of LANES");
  end

  state_t state, state_nxt;
  logic [KW-1:0] k;
  logic [GW-1:0] g;
  logic [RW-1:0] r;
  logic          accept, last_k, last_g, last_r;

  logic [COUNT*IN_SIZE*DATA_W-1:0]    x_q;
  logic [IN_SIZE*OUT_SIZE*DATA_W-1:0] w_q;
  logic [OUT_SIZE*DATA_W-1:0]         b_q;
  logic [COUNT*OUT_SIZE*DATA_W-1:0]   y_q;

  logic [DATA_W-1:0]             x_cur;
  logic [LANES-1:0][DATA_W-1:0]  w_lane, b_lane, y_lane;

  assign accept = bus.in_valid && (state == IDLE);
  assign last_k = (k == KW'(IN_SIZE - 1));
  assign last_g = (g == GW'(GROUPS - 1));
  assign last_r = (r == RW'(COUNT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = MAC;
      MAC:     if (last_k) state_nxt = WRITE;
      WRITE:   state_nxt = (last_g && last_r) ? DONE : MAC;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.busy      = (state == MAC) || (state == WRITE);
  end

  assign bus.data_out = y_q;

  // Operand capture, k/g/r sequencing and element-wise result writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k   <= '0;
      g   <= '0;
      r   <= '0;
      x_q <= '0;
      w_q <= '0;
      b_q <= '0;
      y_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          x_q <= bus.data_in;
          w_q <= bus.weights;
          b_q <= bus.biases;
          k   <= '0;
          g   <= '0;
          r   <= '0;
        end
        MAC: k <= last_k ? '0 : k + 1'b1;
        WRITE: begin
          for (int l = 0; l < LANES; l++)
            y_q[(int'(r)*OUT_SIZE + int'(g)*LANES + l)*DATA_W +: DATA_W] <= y_lane[l];
          if (last_g) begin
            g <= '0;
            r <= last_r ? '0 : r + 1'b1;
          end else begin
            g <= g + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    x_cur = x_q[(int'(r)*IN_SIZE + int'(k))*DATA_W +: DATA_W];
    for (int l = 0; l < LANES; l++) begin
      w_lane[l] = w_q[(int'(k)*OUT_SIZE + int'(g)*LANES + l)*DATA_W +: DATA_W];
      b_lane[l] = b_q[(int'(g)*LANES + l)*DATA_W +: DATA_W];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mac_lane #(
      .IN_SIZE(IN_SIZE),
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .acc_en(state == MAC),
      .first (k == '0),
      .x     (x_cur),
      .w     (w_lane[l]),
      .b     (b_lane[l]),
      .y     (y_lane[l])
    );
  end
endmodule

// File: doc/linear_mac.md
LINEAR_MAC -- requirements
Module: linear_mac

Interface
REQ-001 Parameter IN_SIZE, default 4, input features per row.
REQ-002 Parameter OUT_SIZE, default 4, output features per row.
REQ-003 Parameter COUNT, default 1, rows (batch) per transaction.
REQ-004 Parameter DATA_W, default 32, signed fixed-point word width.
REQ-005 Parameter FRAC_W, default 16, fractional bits (Q(DATA_W-FRAC_W).FRAC_W).
REQ-006 Parameter LANES, default 1, parallel MAC lanes; OUT_SIZE % LANES == 0, checked at elaboration.
REQ-007 Port clk  in  1  sole clock, rising edge.
REQ-008 Port rst  in  1  reset, asynchronous, active-low.
REQ-009 Port in_valid  in  1  operand set valid.
REQ-010 Port in_ready  out  1  block can accept operands.
REQ-011 Port data_in  in  COUNT*IN_SIZE*DATA_W  x, row-major, element [r][i] at index r*IN_SIZE+i.
REQ-012 Port weights  in  IN_SIZE*OUT_SIZE*DATA_W  W, element [i][o] at index i*OUT_SIZE+o.
REQ-013 Port biases  in  OUT_SIZE*DATA_W  b, shared by all rows.
REQ-014 Port out_valid  out  1  result valid.
REQ-015 Port out_ready  in  1  consumer accepts result.
REQ-016 Port data_out  out  COUNT*OUT_SIZE*DATA_W  y = x*W + b, row-major.
REQ-017 Port busy  out  1  high in MAC or WRITE.

Function
REQ-018 FSM states IDLE, MAC, WRITE, DONE; in_ready SHALL be high only in IDLE.
REQ-019 in_valid&&in_ready SHALL register data_in, weights, biases internally and enter MAC; row, group and k counters cleared.
REQ-020 In MAC each lane SHALL add x[r][k]*W[k][g*LANES+l] to its accumulator per cycle, k = 0..IN_SIZE-1; accumulator preloaded with b<<FRAC_W, width 2*DATA_W+$clog2(IN_SIZE)+1 signed.
REQ-021 After k = IN_SIZE-1, WRITE (one cycle) SHALL store per lane: accumulator arithmetic-shifted right FRAC_W (truncate toward -inf), saturated to DATA_W (max 0x7FFF_FFFF, min 0x8000_0000 at DATA_W=32).
REQ-022 WRITE SHALL advance group g, then row r, returning to MAC; after last group of last row SHALL enter DONE.
REQ-023 out_valid SHALL rise exactly COUNT*(OUT_SIZE/LANES)*(IN_SIZE+1) clock edges after the accepting edge.
REQ-024 In DONE out_valid and data_out SHALL hold stable until out_valid&&out_ready; next state IDLE, out_valid low next cycle.
REQ-025 in_valid outside IDLE SHALL be ignored; operand changes after acceptance SHALL not affect the result.
REQ-026 data_out SHALL retain the previous result until overwritten element-by-element during the next transaction.

Reset
REQ-027 rst low SHALL asynchronously force IDLE, all counters and accumulators to 0, data_out to 0, out_valid 0, busy 0; in_ready 1 after release.
REQ-028 Reset during MAC/WRITE/DONE SHALL discard the transaction; no out_valid until a new accept.

Configuration
REQ-029 With LINEAR_MAC_RELU_EN defined, WRITE SHALL replace negative saturated values with 0; undefined, stored value SHALL equal saturated value unchanged; latency identical in both.

Structure
REQ-030 Package linear_pkg SHALL hold the state enum, default width constants, and saturate/shift function.
REQ-031 One sub-module mac_lane (preload, accumulate, shift, saturate, optional ReLU), instantiated LANES times.

Verification
REQ-032 Identity: defaults, x=[1.0,2.0,3.0,4.0] (0x0001_0000..0x0004_0000), W=I, b=0 -> y=x, out_valid exactly 20 edges after accept.
REQ-033 Bias/lanes: LANES=2, W=0, b=[0.5,-0.5,1.0,-1.0] -> y=[0x0000_8000,0xFFFF_8000,0x0001_0000,0xFFFF_0000], latency 10.
REQ-034 Saturation: all x, W = 0x7FFF_0000 -> every y = 0x7FFF_FFFF; all x = 0x8000_0000, W = 0x7FFF_0000 -> every y = 0x8000_0000 (0 with LINEAR_MAC_RELU_EN).
REQ-035 Backpressure: out_ready low 10 cycles after out_valid -> data_out, out_valid stable; in_valid pulses while busy -> ignored, in_ready 0.
REQ-036 Reset mid-MAC (cycle 7) -> out_valid 0, data_out 0, in_ready 1 after release; next transaction (COUNT=2) correct with nominal latency 40.
